ramdma_transfer_ctrl: RTL and testbench
=======================================

Name: ramdma_transfer_ctrl

Overview:
- Bus-master DMA engine that owns port B of the CI-attached 512x32 dual-port SRAM, which the CPU reaches through port A.
- Moves blocks between external bus memory and the SRAM in bursts: bus-to-SRAM and SRAM-to-bus.
- Configured and polled by the CPU through its own custom instruction.
- Sits beside the SRAM CI block; its port-B outputs wire directly to the SRAM's port-B inputs.

Parameters:
customId, 8'h0C, custom-instruction number this block answers to
maxBurst, 8'd255, upper clamp for programmed burstSize (burst length = burstSize+1 words)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  CI start strobe
ciN  in  8  CI number; block responds only when equal to customId
valueA  in  32  [12:10] register select, [9] write enable; [31:13] must be 0, else the CI is a no-op that still returns done
valueB  in  32  write data
done  out  1  CI completion
result  out  32  CI read data, 0 when done is low
sramAddrB  out  9  SRAM port-B address
sramWeB  out  1  SRAM port-B write enable
sramDataB  out  32  SRAM port-B write data
sramQB  in  32  SRAM port-B read data (registered, 1-cycle latency)
busRequest  out  1  bus request
busGrant  in  1  bus grant
beginTransaction  out  1  one-cycle burst start strobe
addressOut  out  32  burst start byte address, valid with beginTransaction
burstSizeOut  out  8  words-1 of current burst, valid with beginTransaction
readNotWrite  out  1  1 = bus read (bus-to-SRAM), valid with beginTransaction
dataIn  in  32  bus read data
dataValidIn  in  1  dataIn valid
dataOut  out  32  bus write data
dataValidOut  out  1  dataOut valid
busyIn  in  1  slave stall; hold dataOut and dataValidOut
endTransactionIn  in  1  slave ends read burst
endTransactionOut  out  1  master ends write burst
errorIn  in  1  bus error

Behaviour:
- Register select: 1 busStart (32 bits, [1:0] forced 0); 2 memStart (9 bits); 3 blockSize (10 bits, words, 0..512); 4 burstSize (8 bits, clamped to maxBurst); 5 control/status.
- Control write, valueB[1:0]: 01 = bus-to-SRAM, 10 = SRAM-to-bus, other values ignored.
- Control writes are ignored while busy. Register writes 1-4 while busy are accepted but take effect only on the next start.
- Status read: bit0 busy, bit1 error, bits[25:16] remaining words.
- CI handshake: done is a registered pulse exactly one cycle after the start cycle (latency 1) for reads and writes; result is valid only in that cycle.
- Reset: all registers 0; FSM IDLE; every output 0.
- FSM states:
  - IDLE: on a valid control start with blockSize!=0, latch working copies: busAddr, memAddr, remaining. Go to REQ. If blockSize==0, stay IDLE with busy=0.
  - REQ: busRequest=1 until busGrant.
  - BEGIN: one cycle with beginTransaction=1. burstSizeOut = min(burstSize+1, remaining)-1.
  - RD: each dataValidIn writes dataIn to memAddr via sramWeB in the same cycle. Then memAddr+1 wrapping 511 to 0, remaining-1.
  - WR: prefetch sramQB one cycle ahead. Present a word with dataValidOut and hold it while busyIn. A word counts as accepted on a cycle with dataValidOut=1 and busyIn=0. After the last accepted word, assert endTransactionOut for 1 cycle.
  - END: drop busRequest; busAddr += 4*(words in burst). If remaining!=0 go to REQ, else IDLE and clear busy.
- RD terminates on endTransactionIn or on word count reached, whichever comes first. Extra dataValidIn beyond the count is ignored, with no SRAM write.
- errorIn in any non-IDLE state: next cycle go to IDLE, drop all bus outputs, set sticky error. Error clears on the next accepted start or reset.
- Simultaneous dataValidIn and endTransactionIn: the word is written, then the burst ends.
- Reset mid-transfer: abort immediately; SRAM contents are not restored.
- Counters and addresses: busAddr wraps mod 2^32; memAddr wraps mod 512; remaining never underflows.

Decomposition:
- Package ramdma_pkg: register-select constants (REG_BUSSTART..REG_CTRL), control codes, FSM state enum, SRAM address width (9).
- One sub-module, ramdma_ci_regs: CI decode, config registers and the done/result pipeline. The FSM and datapath stay in the top module.

Test Plan:
- CI write blockSize=3 then read it back -> done high exactly 1 cycle after start, result=3; result=0 in all other cycles.
- busStart=0x1000, memStart=0, blockSize=8, burstSize=3, ctrl=01 -> two read bursts at 0x1000 and 0x1010, burstSizeOut=3 each; SRAM[0..7] = bus data; busy then 0.
- memStart=510, blockSize=4, ctrl=10, busyIn toggling every other cycle -> dataOut sequence SRAM[510], SRAM[511], SRAM[0], SRAM[1] with no drops or duplicates; endTransactionOut after the 4th accepted word.
- blockSize=5, burstSize=7 -> single burst with burstSizeOut=4; endTransactionIn arriving early after 2 words -> next burst starts at busStart+8 with remaining=3.
- errorIn asserted on 2nd data word -> bus outputs 0 next cycle; status reads busy=0, error=1; next ctrl start clears error.
- Reset asserted mid-burst -> all outputs 0 on the next edge; a control write while busy has no effect.

Source files
------------

// File: rtl/ramdma_pkg.sv
// Shared constants for the RAM DMA transfer controller: CI register map,
// control codes, FSM state encoding and SRAM geometry.
package ramdma_pkg;

  localparam int SRAM_AW = 9;
  localparam logic [9:0] MAX_BLOCK = 10'd512;

  // CI register select values (valueA[12:10])
  localparam logic [2:0] REG_BUSSTART  = 3'd1;
  localparam logic [2:0] REG_MEMSTART  = 3'd2;
  localparam logic [2:0] REG_BLOCKSIZE = 3'd3;
  localparam logic [2:0] REG_BURSTSIZE = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;

  // Control write codes (valueB[1:0])
  localparam logic [1:0] CTRL_B2S = 2'b01;
  localparam logic [1:0] CTRL_S2B = 2'b10;

  // Transfer FSM states
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_BEGIN = 3'd2;
  localparam logic [2:0] ST_RD    = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_WEND  = 3'd5;
  localparam logic [2:0] ST_END   = 3'd6;

endpackage

// File: rtl/ramdma_ci_regs.sv
// CI front end: decodes the custom instruction, holds the configuration
// registers and produces the one-cycle-latency done/result pair.
// Handshake: a CI is taken on any cycle with start=1 and ciN=customId;
// done is high exactly one cycle later and result is meaningful only then.
module ramdma_ci_regs
  import ramdma_pkg::*;
#(
  parameter logic [7:0] customId = 8'h0C,
  parameter logic [7:0] maxBurst = 8'd255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ciN,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic        busy,
  input  logic        error,
  input  logic [9:0]  remaining,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] bus_start,
  output logic [8:0]  mem_start,
  output logic [9:0]  block_size,
  output logic [7:0]  burst_size,
  output logic        ctrl_go,
  output logic [1:0]  ctrl_code
);

  logic        hit;
  logic        legal;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  sel;
  logic [31:0] rd_data;
  logic        unused_bits;

  assign hit       = start && (ciN == customId);
  assign legal     = (valueA[31:13] == 19'd0);
  assign sel       = valueA[12:10];
  assign wr_en     = hit && legal && valueA[9];
  assign rd_en     = hit && legal && !valueA[9];
  assign ctrl_code = valueB[1:0];
  // Only the two defined direction codes count as a start request; the
  // FSM decides whether it can accept it.
  assign ctrl_go   = wr_en && (sel == REG_CTRL) &&
                     ((valueB[1:0] == CTRL_B2S) || (valueB[1:0] == CTRL_S2B));
  assign unused_bits = ^valueA[8:0];

  // Read-data mux; unmapped selects read as zero
  always_comb begin
    rd_data = '0;
    case (sel)
      REG_BUSSTART:  rd_data = bus_start;
      REG_MEMSTART:  rd_data = {23'd0, mem_start};
      REG_BLOCKSIZE: rd_data = {22'd0, block_size};
      REG_BURSTSIZE: rd_data = {24'd0, burst_size};
      REG_CTRL:      rd_data = {6'd0, remaining, 14'd0, error, busy};
      default:       rd_data = '0;
    endcase
  end

  // Configuration writes plus the registered done/result pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      done       <= 1'b0;
      result     <= '0;
      bus_start  <= '0;
      mem_start  <= '0;
      block_size <= '0;
      burst_size <= '0;
    end else begin
      done   <= hit;
      result <= rd_en ? rd_data : 32'd0;
      if (wr_en) begin
        case (sel)
          REG_BUSSTART:  bus_start  <= {valueB[31:2], 2'b00};
          REG_MEMSTART:  mem_start  <= valueB[8:0];
          REG_BLOCKSIZE: block_size <= (valueB[9:0] > MAX_BLOCK) ? MAX_BLOCK : valueB[9:0];
          REG_BURSTSIZE: burst_size <= (valueB[7:0] > maxBurst) ? maxBurst : valueB[7:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ramdma_transfer_ctrl.sv
// Bus-master DMA engine owning SRAM port B. Moves blocks between bus
// memory and the SRAM in bursts, configured through its own CI.
// Working copies of the configuration are latched at start so the CPU may
// reprogram the registers for the next transfer while one is running.
module ramdma_transfer_ctrl
  import ramdma_pkg::*;
#(
  parameter logic [7:0] customId = 8'h0C,
  parameter logic [7:0] maxBurst = 8'd255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          ciN,
  input  logic [31:0]         valueA,
  input  logic [31:0]         valueB,
  output logic                done,
  output logic [31:0]         result,
  output logic [SRAM_AW-1:0]  sramAddrB,
  output logic                sramWeB,
  output logic [31:0]         sramDataB,
  input  logic [31:0]         sramQB,
  output logic                busRequest,
  input  logic                busGrant,
  output logic                beginTransaction,
  output logic [31:0]         addressOut,
  output logic [7:0]          burstSizeOut,
  output logic                readNotWrite,
  input  logic [31:0]         dataIn,
  input  logic                dataValidIn,
  output logic [31:0]         dataOut,
  output logic                dataValidOut,
  input  logic                busyIn,
  input  logic                endTransactionIn,
  output logic                endTransactionOut,
  input  logic                errorIn
);

  logic [2:0]         state;
  logic [31:0]        bus_addr;
  logic [SRAM_AW-1:0] mem_addr;
  logic [9:0]         remaining;
  logic [7:0]         burst_lim;
  logic [8:0]         burst_cnt;
  logic               dir_rd;
  logic               error;
  logic               busy;

  logic [31:0] cfg_bus_start;
  logic [8:0]  cfg_mem_start;
  logic [9:0]  cfg_block_size;
  logic [7:0]  cfg_burst_size;
  logic        ctrl_go;
  logic [1:0]  ctrl_code;

  logic [9:0]  burst_plus;
  logic [9:0]  burst_words;
  logic [9:0]  burst_m1;
  logic        rd_write;
  logic        wr_accept;
  logic        unused_bits;

  assign busy = (state != ST_IDLE);

  ramdma_ci_regs #(
    .customId (customId),
    .maxBurst (maxBurst)
  ) u_regs (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .ciN        (ciN),
    .valueA     (valueA),
    .valueB     (valueB),
    .busy       (busy),
    .error      (error),
    .remaining  (remaining),
    .done       (done),
    .result     (result),
    .bus_start  (cfg_bus_start),
    .mem_start  (cfg_mem_start),
    .block_size (cfg_block_size),
    .burst_size (cfg_burst_size),
    .ctrl_go    (ctrl_go),
    .ctrl_code  (ctrl_code)
  );

  // Burst length is the programmed length, cut short by what is left
  assign burst_plus  = {2'b00, burst_lim} + 10'd1;
  assign burst_words = (burst_plus < remaining) ? burst_plus : remaining;
  assign burst_m1    = burst_words - 10'd1;
  assign unused_bits = ^{burst_m1[9:8], burst_words[9]};

  // A word moves only while the burst count is open; an error cycle moves nothing
  assign rd_write  = (state == ST_RD) && dataValidIn && (burst_cnt != 9'd0) && !errorIn;
  assign wr_accept = (state == ST_WR) && (burst_cnt != 9'd0) && !busyIn && !errorIn;

  // Bus side outputs decoded from state so IDLE (reset, error) drives all zero
  assign busRequest        = (state == ST_REQ) || (state == ST_BEGIN) || (state == ST_RD) ||
                             (state == ST_WR) || (state == ST_WEND);
  assign beginTransaction  = (state == ST_BEGIN);
  assign addressOut        = (state == ST_BEGIN) ? bus_addr : 32'd0;
  assign burstSizeOut      = (state == ST_BEGIN) ? burst_m1[7:0] : 8'd0;
  assign readNotWrite      = (state == ST_BEGIN) && dir_rd;
  assign dataValidOut      = (state == ST_WR) && (burst_cnt != 9'd0);
  assign dataOut           = dataValidOut ? sramQB : 32'd0;
  assign endTransactionOut = (state == ST_WEND);

  // Port B: on an accepted write-burst word the next address is presented
  // at once so the registered SRAM read lands with no bubble; otherwise the
  // address holds, which also holds sramQB while the slave stalls.
  assign sramAddrB = wr_accept ? (mem_addr + 9'd1) : mem_addr;
  assign sramWeB   = rd_write;
  assign sramDataB = rd_write ? dataIn : 32'd0;

  // Transfer FSM and working counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bus_addr  <= '0;
      mem_addr  <= '0;
      remaining <= '0;
      burst_lim <= '0;
      burst_cnt <= '0;
      dir_rd    <= 1'b0;
      error     <= 1'b0;
    end else if ((state != ST_IDLE) && errorIn) begin
      state <= ST_IDLE;
      error <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_go) begin
            error <= 1'b0;
            if (cfg_block_size != 10'd0) begin
              bus_addr  <= cfg_bus_start;
              mem_addr  <= cfg_mem_start;
              remaining <= cfg_block_size;
              burst_lim <= cfg_burst_size;
              dir_rd    <= (ctrl_code == CTRL_B2S);
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: if (busGrant) state <= ST_BEGIN;
        ST_BEGIN: begin
          burst_cnt <= burst_words[8:0];
          state     <= dir_rd ? ST_RD : ST_WR;
        end
        ST_RD: begin
          if (rd_write) begin
            mem_addr  <= mem_addr + 9'd1;
            remaining <= remaining - 10'd1;
            burst_cnt <= burst_cnt - 9'd1;
            bus_addr  <= bus_addr + 32'd4;
          end
          if (endTransactionIn || (rd_write && (burst_cnt == 9'd1))) state <= ST_END;
        end
        ST_WR: begin
          if (wr_accept) begin
            mem_addr  <= mem_addr + 9'd1;
            remaining <= remaining - 10'd1;
            burst_cnt <= burst_cnt - 9'd1;
            bus_addr  <= bus_addr + 32'd4;
            if (burst_cnt == 9'd1) state <= ST_WEND;
          end
        end
        ST_WEND: state <= ST_END;
        ST_END:  state <= (remaining != 10'd0) ? ST_REQ : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramdma_transfer_ctrl.sv
// Directed bench for ramdma_transfer_ctrl: CI register access, read and
// write bursts, early slave termination, bus error and mid-burst reset.
module tb_ramdma_transfer_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  ciN = '0;
  logic [31:0] valueA = '0;
  logic [31:0] valueB = '0;
  logic        done;
  logic [31:0] result;
  logic [8:0]  sramAddrB;
  logic        sramWeB;
  logic [31:0] sramDataB;
  logic [31:0] sramQB;
  logic        busRequest;
  logic        busGrant = 1'b0;
  logic        beginTransaction;
  logic [31:0] addressOut;
  logic [7:0]  burstSizeOut;
  logic        readNotWrite;
  logic [31:0] dataIn = '0;
  logic        dataValidIn = 1'b0;
  logic [31:0] dataOut;
  logic        dataValidOut;
  logic        busyIn = 1'b0;
  logic        endTransactionIn = 1'b0;
  logic        endTransactionOut;
  logic        errorIn = 1'b0;

  logic [31:0] mem [512];
  logic        tb_we = 1'b0;
  logic [8:0]  tb_addr = '0;
  logic [31:0] tb_data = '0;

  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] rd;

  ramdma_transfer_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .ciN               (ciN),
    .valueA            (valueA),
    .valueB            (valueB),
    .done              (done),
    .result            (result),
    .sramAddrB         (sramAddrB),
    .sramWeB           (sramWeB),
    .sramDataB         (sramDataB),
    .sramQB            (sramQB),
    .busRequest        (busRequest),
    .busGrant          (busGrant),
    .beginTransaction  (beginTransaction),
    .addressOut        (addressOut),
    .burstSizeOut      (burstSizeOut),
    .readNotWrite      (readNotWrite),
    .dataIn            (dataIn),
    .dataValidIn       (dataValidIn),
    .dataOut           (dataOut),
    .dataValidOut      (dataValidOut),
    .busyIn            (busyIn),
    .endTransactionIn  (endTransactionIn),
    .endTransactionOut (endTransactionOut),
    .errorIn           (errorIn)
  );

  // Clock
  always #5 clock = ~clock;

  // SRAM port B model: registered read, write from DUT or bench preload
  always @(posedge clock) begin
    if (sramWeB) mem[sramAddrB] <= sramDataB;
    else if (tb_we) mem[tb_addr] <= tb_data;
    sramQB <= mem[sramAddrB];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, busRequest, beginTransaction, readNotWrite, sramWeB,
                        dataValidOut, endTransactionOut, done}, 32'd0);
    chk({tag, "_addr"}, addressOut, 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_dout"}, dataOut, 32'd0);
    chk({tag, "_sram"}, {15'd0, sramAddrB, burstSizeOut}, 32'd0);
    chk({tag, "_sdata"}, sramDataB, 32'd0);
  endtask

  task automatic ci_raw(input logic [7:0] n, input logic [31:0] va, input logic [31:0] vb,
                        input logic exp_done, output logic [31:0] rdv);
    @(negedge clock);
    start = 1'b1; ciN = n; valueA = va; valueB = vb;
    #1;
    chk("ci_pre_done", {31'd0, done}, 32'd0);
    chk("ci_pre_result", result, 32'd0);
    @(negedge clock);
    start = 1'b0; ciN = '0; valueA = '0; valueB = '0;
    #1;
    chk("ci_done", {31'd0, done}, {31'd0, exp_done});
    rdv = result;
    if (!done) chk("ci_result_low", result, 32'd0);
  endtask

  task automatic ci(input logic [2:0] sel, input logic we, input logic [31:0] d,
                    output logic [31:0] rdv);
    ci_raw(8'h0C, {19'd0, sel, we, 9'd0}, d, 1'b1, rdv);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_we = 1'b1; tb_addr = a; tb_data = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  task automatic wait_begin(input logic [31:0] exp_addr, input logic [7:0] exp_bs,
                            input logic exp_rnw);
    busGrant = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      #1;
      if (beginTransaction) break;
    end
    busGrant = 1'b0;
    chk("begin_seen", {31'd0, beginTransaction}, 32'd1);
    chk("begin_addr", addressOut, exp_addr);
    chk("begin_bsize", {24'd0, burstSizeOut}, {24'd0, exp_bs});
    chk("begin_rnw", {31'd0, readNotWrite}, {31'd0, exp_rnw});
  endtask

  task automatic rd_words(input int n, input logic [31:0] base, input logic [8:0] ma,
                          input logic extra, input logic et_last);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      dataValidIn = 1'b1;
      dataIn = base + k;
      endTransactionIn = et_last && (k == n - 1);
      #1;
      chk("rd_we", {31'd0, sramWeB}, 32'd1);
      chk("rd_addr", {23'd0, sramAddrB}, {23'd0, ma + 9'(k)});
    end
    @(negedge clock);
    endTransactionIn = 1'b0;
    dataValidIn = extra;
    dataIn = 32'hDEAD_BEEF;
    #1;
    chk("rd_end_req", {31'd0, busRequest}, 32'd0);
    chk("rd_extra_we", {31'd0, sramWeB}, 32'd0);
    dataValidIn = 1'b0;
  endtask

  task automatic wr_check(input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge clock);
      busyIn = (n % 2 == 0);
      n++;
      #1;
      if (dataValidOut) begin
        chk("wr_data", dataOut, exp_q[0]);
        if (!busyIn) void'(exp_q.pop_front());
      end
    end
    chk("wr_drained", exp_q.size(), 32'd0);
    @(negedge clock);
    busyIn = 1'b0;
    #1;
    chk("wr_end_out", {31'd0, endTransactionOut}, 32'd1);
    chk("wr_dvo_after", {31'd0, dataValidOut}, 32'd0);
    @(negedge clock);
    #1;
    chk("wr_end_pulse", {31'd0, endTransactionOut}, 32'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    #1;
    outputs_zero("reset");
    reset = 1'b0;

    // CI register access and boundaries
    ci(3'd3, 1'b1, 32'd3, rd);
    ci(3'd3, 1'b0, 32'd0, rd);
    chk("blocksize_rb", rd, 32'd3);
    ci_raw(8'h0C, {19'd1, 3'd3, 1'b1, 9'd0}, 32'd9, 1'b1, rd);
    ci(3'd3, 1'b0, 32'd0, rd);
    chk("illegal_a_noop", rd, 32'd3);
    ci_raw(8'h0D, {19'd0, 3'd3, 1'b1, 9'd0}, 32'd7, 1'b0, rd);
    ci(3'd3, 1'b0, 32'd0, rd);
    chk("wrong_cin_noop", rd, 32'd3);
    ci(3'd3, 1'b1, 32'd600, rd);
    ci(3'd3, 1'b0, 32'd0, rd);
    chk("blocksize_clamp", rd, 32'd512);
    ci(3'd1, 1'b1, 32'h0000_1003, rd);
    ci(3'd1, 1'b0, 32'd0, rd);
    chk("busstart_align", rd, 32'h0000_1000);

    // Bus-to-SRAM, two bursts of 4
    ci(3'd1, 1'b1, 32'h0000_1000, rd);
    ci(3'd2, 1'b1, 32'd0, rd);
    ci(3'd3, 1'b1, 32'd8, rd);
    ci(3'd4, 1'b1, 32'd3, rd);
    ci(3'd5, 1'b1, 32'd1, rd);
    wait_begin(32'h0000_1000, 8'd3, 1'b1);
    rd_words(4, 32'hA000_0000, 9'd0, 1'b0, 1'b0);
    wait_begin(32'h0000_1010, 8'd3, 1'b1);
    rd_words(4, 32'hA000_0004, 9'd4, 1'b1, 1'b0);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t2_status", rd, 32'd0);
    for (int k = 0; k < 8; k++) chk("t2_mem", mem[k], 32'hA000_0000 + k);

    // SRAM-to-bus across the 511->0 wrap with a stalling slave
    preload(9'd510, 32'h0000_B510);
    preload(9'd511, 32'h0000_B511);
    ci(3'd1, 1'b1, 32'h0000_2000, rd);
    ci(3'd2, 1'b1, 32'd510, rd);
    ci(3'd3, 1'b1, 32'd4, rd);
    ci(3'd5, 1'b1, 32'd2, rd);
    wait_begin(32'h0000_2000, 8'd3, 1'b0);
    exp_q.push_back(32'h0000_B510);
    exp_q.push_back(32'h0000_B511);
    exp_q.push_back(32'hA000_0000);
    exp_q.push_back(32'hA000_0001);
    wr_check(20);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t3_status", rd, 32'd0);

    // Early endTransactionIn; writes while busy
    ci(3'd1, 1'b1, 32'h0000_3000, rd);
    ci(3'd2, 1'b1, 32'd20, rd);
    ci(3'd3, 1'b1, 32'd5, rd);
    ci(3'd4, 1'b1, 32'd7, rd);
    ci(3'd5, 1'b1, 32'd1, rd);
    wait_begin(32'h0000_3000, 8'd4, 1'b1);
    rd_words(2, 32'hC000_0000, 9'd20, 1'b0, 1'b1);
    ci(3'd5, 1'b1, 32'd2, rd);
    ci(3'd4, 1'b1, 32'd0, rd);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t4_status_mid", rd, 32'h0003_0001);
    wait_begin(32'h0000_3008, 8'd2, 1'b1);
    rd_words(3, 32'hD000_0000, 9'd22, 1'b0, 1'b0);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t4_status_end", rd, 32'd0);
    chk("t4_mem20", mem[20], 32'hC000_0000);
    chk("t4_mem21", mem[21], 32'hC000_0001);
    chk("t4_mem22", mem[22], 32'hD000_0000);
    chk("t4_mem24", mem[24], 32'hD000_0002);

    // Bus error on the second word
    ci(3'd1, 1'b1, 32'h0000_4000, rd);
    ci(3'd2, 1'b1, 32'd100, rd);
    ci(3'd3, 1'b1, 32'd4, rd);
    ci(3'd4, 1'b1, 32'd3, rd);
    ci(3'd5, 1'b1, 32'd1, rd);
    wait_begin(32'h0000_4000, 8'd3, 1'b1);
    @(negedge clock);
    dataValidIn = 1'b1; dataIn = 32'hE000_0000;
    #1;
    chk("t5_we0", {31'd0, sramWeB}, 32'd1);
    @(negedge clock);
    dataIn = 32'hE000_0001; errorIn = 1'b1;
    @(negedge clock);
    errorIn = 1'b0; dataIn = 32'hE000_0002;
    #1;
    chk("t5_err_req", {31'd0, busRequest}, 32'd0);
    chk("t5_err_we", {31'd0, sramWeB}, 32'd0);
    dataValidIn = 1'b0;
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t5_err_status", rd & 32'd3, 32'd2);
    ci(3'd3, 1'b1, 32'd1, rd);
    ci(3'd5, 1'b1, 32'd1, rd);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t5_err_cleared", rd, 32'h0001_0001);
    wait_begin(32'h0000_4000, 8'd0, 1'b1);
    rd_words(1, 32'hF000_0000, 9'd100, 1'b0, 1'b0);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t5_status_end", rd, 32'd0);

    // Reset during a write burst
    ci(3'd1, 1'b1, 32'h0000_5000, rd);
    ci(3'd2, 1'b1, 32'd0, rd);
    ci(3'd3, 1'b1, 32'd4, rd);
    ci(3'd5, 1'b1, 32'd2, rd);
    wait_begin(32'h0000_5000, 8'd3, 1'b0);
    @(negedge clock);
    busyIn = 1'b0;
    #1;
    chk("t6_dvo", {31'd0, dataValidOut}, 32'd1);
    chk("t6_dout", dataOut, 32'hA000_0000);
    reset = 1'b1;
    @(negedge clock);
    #1;
    outputs_zero("midreset");
    reset = 1'b0;
    ci(3'd3, 1'b0, 32'd0, rd);
    chk("t6_blocksize_cleared", rd, 32'd0);
    ci(3'd5, 1'b1, 32'd1, rd);
    ci(3'd5, 1'b0, 32'd0, rd);
    chk("t6_zero_block_idle", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
